// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the systolic-array feeder.
package systolic_pkg;

  localparam int unsigned DEF_ARRAY_SIZE = 8;
  localparam int unsigned DEF_DATA_WIDTH = 4;
  localparam int unsigned PERF_CNT_W     = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } feeder_state_e;

  // Counter wide enough to hold the value n itself, not just n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/skew_line.sv
// Resettable shift register delaying one lane by DEPTH cycles.
module skew_line #(
  parameter int unsigned DEPTH      = 1,
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DATA_WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= data_i;
      for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Loads a weight tile then streams skewed activation vectors into a systolic array.
// Optional FEEDER_PERF_CNT_EN adds a busy-cycle counter output (cycle_count).
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             w_valid,
  output logic                             w_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] w_data,
  input  logic                             a_valid,
  output logic                             a_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] a_data,
  input  logic                             a_last,
  output logic                             load,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] weights,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] activations,
  output logic                             busy,
  output logic                             done
`ifdef FEEDER_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0]            cycle_count
`endif
);

  localparam int unsigned BUS_W = ARRAY_SIZE * DATA_WIDTH;
  localparam int unsigned ROW_W = cnt_width(ARRAY_SIZE);

  feeder_state_e    state_q, state_d;
  logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
  logic [ROW_W-1:0] drain_cnt_q, drain_cnt_d;
  logic             load_q, w_ready_q, a_ready_q, busy_q, done_q;
  logic [BUS_W-1:0] weights_q;
  logic [BUS_W-1:0] inject_vec;
  logic             w_fire, a_fire;

  assign w_fire = w_valid && (state_q == LOAD_W);
  assign a_fire = a_valid && (state_q == STREAM);

  // Next-state and counter logic.
  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD_W;
          row_cnt_d = '0;
        end
      end
      LOAD_W: begin
        if (w_fire) begin
          row_cnt_d = row_cnt_q + ROW_W'(1);
          if (row_cnt_d == ROW_W'(ARRAY_SIZE)) state_d = STREAM;
        end
      end
      STREAM: begin
        if (a_fire && a_last) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q + ROW_W'(1);
        if (drain_cnt_d == ROW_W'(ARRAY_SIZE)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered handshake/status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      row_cnt_q   <= '0;
      drain_cnt_q <= '0;
      load_q      <= 1'b0;
      weights_q   <= '0;
      w_ready_q   <= 1'b0;
      a_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      load_q      <= w_fire;
      weights_q   <= w_fire ? w_data : '0;
      w_ready_q   <= (state_d == LOAD_W);
      a_ready_q   <= (state_d == STREAM);
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
    end
  end

  assign load    = load_q;
  assign weights = weights_q;
  assign w_ready = w_ready_q;
  assign a_ready = a_ready_q;
  assign busy    = busy_q;
  assign done    = done_q;

  // Non-accepted cycles push a zero bubble through every lane.
  assign inject_vec = a_fire ? a_data : '0;

  for (genvar i = 0; i < int'(ARRAY_SIZE); i++) begin : g_lane
    skew_line #(
      .DEPTH      (i + 1),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_skew (
      .clk    (clk),
      .rst_n  (reset),
      .data_i (inject_vec[i*DATA_WIDTH +: DATA_WIDTH]),
      .data_o (activations[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

`ifdef FEEDER_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] perf_cnt_q;

  // Busy-cycle count of the current/last job, held once the block is idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_cnt_q <= '0;
    end else if (state_q == IDLE && start) begin
      perf_cnt_q <= '0;
    end else if (state_q != IDLE && perf_cnt_q != '1) begin
      perf_cnt_q <= perf_cnt_q + PERF_CNT_W'(1);
    end
  end

  assign cycle_count = perf_cnt_q;
`endif

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 The block SHALL have parameter ARRAY_SIZE, default 8, giving the array dimension (number of lanes).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 4, giving the element width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: pulse that begins one weight-load plus stream job.
REQ-006 The block SHALL have port w_valid / w_ready, input / output, 1 bit each: weight-row handshake.
REQ-007 The block SHALL have port w_data, input, ARRAY_SIZE*DATA_WIDTH: one weight row, lane i in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have port a_valid / a_ready, input / output, 1 bit each: activation-vector handshake.
REQ-009 The block SHALL have port a_data, input, ARRAY_SIZE*DATA_WIDTH: one unskewed activation vector, same lane packing as w_data.
REQ-010 The block SHALL have port a_last, input, 1 bit: marks the final activation vector of the job.
REQ-011 The block SHALL have port load, output, 1 bit: weight-load strobe to the systolic array.
REQ-012 The block SHALL have port weights, output, ARRAY_SIZE*DATA_WIDTH: weight row to the array.
REQ-013 The block SHALL have port activations, output, ARRAY_SIZE*DATA_WIDTH: skewed activations to the array.
REQ-014 The block SHALL have port busy / done, output, 1 bit each: job in progress / one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD_W, STREAM, DRAIN, DONE.
REQ-016 In IDLE, start=1 SHALL move the FSM to LOAD_W on the next edge; start SHALL be ignored in every other state.
REQ-017 w_ready SHALL be 1 only in LOAD_W, and a_ready SHALL be 1 only in STREAM.
REQ-018 Each accepted weight row SHALL appear on weights with load=1 exactly one cycle after acceptance; cycles without acceptance SHALL drive load=0 and weights=0.
REQ-019 After exactly ARRAY_SIZE accepted rows, the FSM SHALL enter STREAM; row counter width SHALL be $clog2(ARRAY_SIZE)+1.
REQ-020 Lane i of an accepted activation vector SHALL appear on activations lane i exactly i+1 cycles after acceptance (lane 0: 1 cycle; lane 7: 8 cycles).
REQ-021 A STREAM cycle without an accepted vector SHALL inject a zero vector into the skew line, producing zero bubbles on every lane at the same relative delays.
REQ-022 Acceptance with a_last=1 SHALL move the FSM to DRAIN, which SHALL last exactly ARRAY_SIZE cycles while zeros are injected, then move to DONE.
REQ-023 DONE SHALL last one cycle, assert done=1, and return to IDLE.
REQ-024 busy SHALL be 1 in LOAD_W, STREAM, DRAIN and DONE, and 0 in IDLE.
REQ-025 If a_last arrives on the first STREAM vector, the job SHALL still drain fully; a lane value SHALL never be dropped or duplicated.

Reset
REQ-026 reset=0 SHALL immediately force state IDLE, clear all counters and skew registers, and drive load, weights, activations, w_ready, a_ready, busy and done to 0.
REQ-027 Reset asserted mid-job SHALL abort the job with no done pulse; after release the block SHALL be idle.

Configuration
REQ-028 With FEEDER_PERF_CNT_EN defined, the block SHALL add output cycle_count (16 bits): cycles spent busy in the last job, cleared on start, saturating at 16'hFFFF, held after DONE. Without the macro, the port and its logic SHALL be absent.

Structure
REQ-029 Package systolic_pkg SHALL hold the FSM state enum and the default ARRAY_SIZE/DATA_WIDTH constants.
REQ-030 The per-lane delay SHALL be sub-module skew_line (parameterised depth, DATA_WIDTH wide, resettable shift register), instantiated once per lane.

Verification
REQ-031 Reset-values check: hold reset=0 and toggle clk -> all outputs are 0; on release the block stays in IDLE with busy=0.
REQ-032 Weight-load check: start, then 8 rows of {8,7,6,5,4,3,2,1} back-to-back -> load=1 for exactly 8 cycles with that value on weights, then STREAM.
REQ-033 Skew check: vectors with all lanes = t for t=1..8, a_last on t=8 -> lane i shows t at cycle t+i after the first acceptance; done pulses after 8 drain cycles.
REQ-034 Bubble check: a_valid low for 2 cycles mid-stream -> zeros appear on each lane at the matching skewed offset.
REQ-035 Abort check: reset=0 during STREAM -> immediate all-zero outputs, no done pulse; a fresh start then completes normally.
REQ-036 Perf-counter check (FEEDER_PERF_CNT_EN only): the REQ-033 job gives cycle_count = 8+8+8+1 = 25.
